id_ex_register: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32I pipeline. Captures the decode-stage

---
 rtl/id_ex_register.sv | 145 ++++++++++++++
 tb/tb_id_ex_register.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: registers the decode control bundle and operands for EX.
// Invalid or illegal decode slots become clean bubbles, so unknown control never reaches EX.
module id_ex_register #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic            id_we,
  input  logic [1:0]      id_result_src,
  input  logic            id_mem_we,
  input  logic            id_alu_src,
  input  logic [1:0]      id_jump,
  input  logic [2:0]      id_branch,
  input  logic [1:0]      id_alu_op,
  input  logic            id_lui,
  input  logic [2:0]      id_func3,
  input  logic            id_func7b5,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_pc_plus4,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  output logic            ex_valid,
  output logic            ex_we,
  output logic [1:0]      ex_result_src,
  output logic            ex_mem_we,
  output logic            ex_alu_src,
  output logic [1:0]      ex_jump,
  output logic [2:0]      ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic            ex_lui,
  output logic [2:0]      ex_func3,
  output logic            ex_func7b5,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            illegal_op
);

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [1:0]      result_src;
    logic            mem_we;
    logic            alu_src;
    logic [1:0]      jump;
    logic [2:0]      branch;
    logic [1:0]      alu_op;
    logic            lui;
    logic [2:0]      func3;
    logic            func7b5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_bundle_t;

  ex_bundle_t id_bundle;
  ex_bundle_t ex_q;
  logic       opcode_legal;

  // An unknown opcode matches no item and therefore counts as illegal.
  always_comb begin
    opcode_legal = 1'b0;
    case (id_opcode)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    id_bundle            = '0;
    id_bundle.valid      = 1'b1;
    id_bundle.we         = id_we;
    id_bundle.result_src = id_result_src;
    id_bundle.mem_we     = id_mem_we;
    id_bundle.alu_src    = id_alu_src;
    id_bundle.jump       = id_jump;
    id_bundle.branch     = id_branch;
    id_bundle.alu_op     = id_alu_op;
    id_bundle.lui        = id_lui;
    id_bundle.func3      = id_func3;
    id_bundle.func7b5    = id_func7b5;
    id_bundle.pc         = id_pc;
    id_bundle.pc_plus4   = id_pc_plus4;
    id_bundle.rd1        = id_rd1;
    id_bundle.rd2        = id_rd2;
    id_bundle.imm        = id_imm;
    id_bundle.rs1        = id_rs1;
    id_bundle.rs2        = id_rs2;
    id_bundle.rd         = id_rd;
  end

  // A bubble is the all-zero bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      if (id_valid && opcode_legal) ex_q <= id_bundle;
      else                          ex_q <= '0;
      if (id_valid && !opcode_legal) illegal_op <= 1'b1;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_we         = ex_q.we;
  assign ex_result_src = ex_q.result_src;
  assign ex_mem_we     = ex_q.mem_we;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_jump       = ex_q.jump;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_lui        = ex_q.lui;
  assign ex_func3      = ex_q.func3;
  assign ex_func7b5    = ex_q.func7b5;
  assign ex_pc         = ex_q.pc;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: each stimulus cycle queues the expected EX
// bundle and illegal_op; a negedge monitor pops and compares.
module tb_id_ex_register;
  localparam int XLEN = 32;
  localparam int K_LOAD = 0, K_BUBBLE = 1, K_HOLD = 2;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [1:0]      result_src;
    logic            mem_we;
    logic            alu_src;
    logic [1:0]      jump;
    logic [2:0]      branch;
    logic [1:0]      alu_op;
    logic            lui;
    logic [2:0]      func3;
    logic            func7b5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } out_t;

  typedef struct packed {
    out_t bundle;
    logic ill;
    logic [7:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, stall = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0;
  logic [6:0] id_opcode = '0;
  logic id_we = '0, id_mem_we = '0, id_alu_src = '0, id_lui = '0, id_func7b5 = '0;
  logic [1:0] id_result_src = '0, id_jump = '0, id_alu_op = '0;
  logic [2:0] id_branch = '0, id_func3 = '0;
  logic [XLEN-1:0] id_pc = '0, id_pc_plus4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic ex_valid, ex_we, ex_mem_we, ex_alu_src, ex_lui, ex_func7b5, illegal_op;
  logic [1:0] ex_result_src, ex_jump, ex_alu_op;
  logic [2:0] ex_branch, ex_func3;
  logic [XLEN-1:0] ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;

  id_ex_register #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_we(id_we),
    .id_result_src(id_result_src), .id_mem_we(id_mem_we), .id_alu_src(id_alu_src),
    .id_jump(id_jump), .id_branch(id_branch), .id_alu_op(id_alu_op), .id_lui(id_lui),
    .id_func3(id_func3), .id_func7b5(id_func7b5), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_result_src(ex_result_src),
    .ex_mem_we(ex_mem_we), .ex_alu_src(ex_alu_src), .ex_jump(ex_jump),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_lui(ex_lui),
    .ex_func3(ex_func3), .ex_func7b5(ex_func7b5), .ex_pc(ex_pc),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  out_t act;
  always_comb begin
    act            = '0;
    act.valid      = ex_valid;
    act.we         = ex_we;
    act.result_src = ex_result_src;
    act.mem_we     = ex_mem_we;
    act.alu_src    = ex_alu_src;
    act.jump       = ex_jump;
    act.branch     = ex_branch;
    act.alu_op     = ex_alu_op;
    act.lui        = ex_lui;
    act.func3      = ex_func3;
    act.func7b5    = ex_func7b5;
    act.pc         = ex_pc;
    act.pc_plus4   = ex_pc_plus4;
    act.rd1        = ex_rd1;
    act.rd2        = ex_rd2;
    act.imm        = ex_imm;
    act.rs1        = ex_rs1;
    act.rs2        = ex_rs2;
    act.rd         = ex_rd;
  end

  exp_t sb_q[$];
  out_t exp_cur = '0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Monitor: one expected entry per clock edge, compared on the following negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (act === e.bundle) n_pass++;
        else $display("FAIL bundle step%0d: got %h expected %h", e.tag, act, e.bundle);
        n_checks++;
        if (illegal_op === e.ill) n_pass++;
        else $display("FAIL illegal_op step%0d: got %b expected %b", e.tag, illegal_op, e.ill);
        n_checks++;
        if (!$isunknown({act, illegal_op})) n_pass++;
        else $display("FAIL no_x step%0d: got %h expected no unknown bits", e.tag, act);
      end
    end
  end

  // Fills every id_* field with a distinct value derived from seed.
  task automatic drive_instr(input logic v, input logic [6:0] op, input logic [31:0] seed);
    id_valid      = v;
    id_opcode     = op;
    id_pc         = seed;
    id_pc_plus4   = seed + 32'd4;
    id_rd1        = seed ^ 32'hA5A5_0000;
    id_rd2        = ~seed;
    id_imm        = {seed[15:0], seed[31:16]};
    id_rs1        = seed[4:0];
    id_rs2        = seed[9:5];
    id_rd         = seed[14:10];
    id_we         = seed[16];
    id_result_src = seed[18:17];
    id_mem_we     = seed[19];
    id_alu_src    = seed[20];
    id_jump       = seed[22:21];
    id_branch     = seed[25:23];
    id_alu_op     = seed[27:26];
    id_lui        = seed[28];
    id_func3      = seed[31:29];
    id_func7b5    = seed[3];
  endtask

  task automatic ctrl_x();
    id_we = 'x; id_result_src = 'x; id_mem_we = 'x; id_alu_src = 'x; id_jump = 'x;
    id_branch = 'x; id_alu_op = 'x; id_lui = 'x; id_func3 = 'x; id_func7b5 = 'x;
  endtask

  int step_no = 0;

  // Applies rst/stall/flush with the inputs already set, queues the expected result, clocks once.
  task automatic step(input int kind, input logic exp_ill,
                      input logic r, input logic s, input logic f);
    exp_t e;
    rst = r; stall = s; flush = f;
    if (kind == K_BUBBLE) exp_cur = '0;
    else if (kind == K_LOAD) begin
      exp_cur = '0;
      exp_cur.valid = 1'b1;        exp_cur.we = id_we;
      exp_cur.result_src = id_result_src; exp_cur.mem_we = id_mem_we;
      exp_cur.alu_src = id_alu_src; exp_cur.jump = id_jump;
      exp_cur.branch = id_branch;  exp_cur.alu_op = id_alu_op;
      exp_cur.lui = id_lui;        exp_cur.func3 = id_func3;
      exp_cur.func7b5 = id_func7b5; exp_cur.pc = id_pc;
      exp_cur.pc_plus4 = id_pc_plus4; exp_cur.rd1 = id_rd1;
      exp_cur.rd2 = id_rd2;        exp_cur.imm = id_imm;
      exp_cur.rs1 = id_rs1;        exp_cur.rs2 = id_rs2;
      exp_cur.rd = id_rd;
    end
    e.bundle = exp_cur;
    e.ill    = exp_ill;
    e.tag    = 8'(step_no);
    sb_q.push_back(e);
    step_no++;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [6:0] legal_ops [8];

  initial begin
    legal_ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111};
    @(negedge clk); #1;

    // Reset with a legal valid slot and stall/flush present: reset wins.
    drive_instr(1'b1, 7'b0110011, 32'hDEAD_BEEF);
    step(K_BUBBLE, 1'b0, 1'b1, 1'b1, 1'b1);
    step(K_BUBBLE, 1'b0, 1'b1, 1'b0, 1'b0);

    // R-type load with the hand-picked fields.
    drive_instr(1'b1, 7'b0110011, 32'h1234_5678);
    id_we = 1'b1; id_alu_op = 2'b10; id_rd = 5'd5; id_rd1 = 32'h11;
    step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ex_we === 1'b1 && ex_alu_op === 2'b10 && ex_rd === 5'd5 && ex_rd1 === 32'h11 && ex_valid === 1'b1)
      n_pass++;
    else $display("FAIL rtype_fields: got we=%b alu_op=%b rd=%0d rd1=%h valid=%b expected 1 10 5 11 1",
                  ex_we, ex_alu_op, ex_rd, ex_rd1, ex_valid);

    // Stall three cycles while inputs change, then release.
    drive_instr(1'b1, 7'b0010011, 32'h0BAD_F00D); step(K_HOLD, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_instr(1'b1, 7'b0000011, 32'hCAFE_0001); step(K_HOLD, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_instr(1'b0, 7'b0100011, 32'h5555_AAAA); step(K_HOLD, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_instr(1'b1, 7'b0100011, 32'hFEDC_BA98); step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush with stall on a valid beq.
    drive_instr(1'b1, 7'b1100011, 32'h7777_1234); id_branch = 3'b001; id_we = 1'b1;
    step(K_BUBBLE, 1'b0, 1'b0, 1'b1, 1'b1);

    // Every legal opcode loads.
    for (int i = 0; i < 8; i++) begin
      drive_instr(1'b1, legal_ops[i], 32'h1357_9BDF + 32'(i) * 32'h0101_0107);
      step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Invalid slot with a legal opcode becomes a bubble.
    drive_instr(1'b0, 7'b0110011, 32'hA1B2_C3D4); step(K_BUBBLE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b0110111, 32'h2468_ACE0); step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal opcode while stalled, flushed, or invalid leaves illegal_op clear.
    drive_instr(1'b1, 7'b1111111, 32'h0); ctrl_x();
    step(K_HOLD, 1'b0, 1'b0, 1'b1, 1'b0);
    step(K_BUBBLE, 1'b0, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b0;
    step(K_BUBBLE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal load with unknown controls: bubble and sticky flag.
    drive_instr(1'b1, 7'b0110011, 32'h9999_8888); step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b1111111, 32'h0); ctrl_x();
    step(K_BUBBLE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b0000011, 32'h3141_5926); step(K_LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b0010111, 32'h2718_2818); step(K_BUBBLE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_instr(1'b1, 7'b1101111, 32'h6666_0F0F); step(K_LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
    step(K_BUBBLE, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset clears the sticky flag even with stall and flush asserted.
    step(K_BUBBLE, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_instr(1'b1, 7'b1100111, 32'h0F1E_2D3C); step(K_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
